// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks WIDTH bits LSB first.
// Optional subtract mode is compiled in with `define BSA_SUB_EN.
module bsa_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module bit_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef BSA_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             accept;

    // Subtract is a + ~b + 1; cout=1 then means no borrow.
`ifdef BSA_SUB_EN
    assign b_load = sub_i ? ~b_i : b_i;
    assign c_load = sub_i ? 1'b1 : cin_i;
`else
    assign b_load = b_i;
    assign c_load = cin_i;
`endif

    assign accept = in_valid_i && (state_q == S_IDLE);

    bsa_full_adder u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // The extra RUN cycle with last_q set commits the shifted sum.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        last_d   = last_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_sr_d  = a_i;
                    b_sr_d  = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_q) begin
                    sum_d   = sum_sr_q;
                    cout_d  = carry_q;
                    last_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                    a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                    carry_d  = fa_c;
                    if (cnt_q == CNT_LAST) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            last_q   <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            last_q   <= last_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_RUN);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed bench for bit_serial_add_ctrl at WIDTH=8.
// Subtract vectors are included when BSA_SUB_EN is defined.
module tb_bit_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_ni;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    bit_serial_add_ctrl #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
`ifdef BSA_SUB_EN
        .sub_i       (sub),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands on a falling edge; the next rising edge accepts.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                            input logic cv, input logic sv);
        a = av;
        b = bv;
        cin = cv;
        sub = sv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'h00);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        start_op(8'h35, 8'h4A, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("op1_busy", 32'(busy), 32'd1);
        chk("op1_in_ready", 32'(in_ready), 32'd0);
        wait_done(n);
        chk("op1_latency", 32'(n), 32'd9);
        chk("op1_sum", 32'(sum), 32'h7F);
        chk("op1_cout", 32'(cout), 32'd0);
        release_out();
        chk("op1_idle_ready", 32'(in_ready), 32'd1);
        chk("op1_idle_valid", 32'(out_valid), 32'd0);

        start_op(8'hFF, 8'h01, 1'b1, 1'b0);
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        wait_done(n);
        chk("op2_latency", 32'(n), 32'd9);
        chk("op2_sum", 32'(sum), 32'h01);
        chk("op2_cout", 32'(cout), 32'd1);
        chk("op2_done_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        release_out();
        chk("op2_idle_ready", 32'(in_ready), 32'd1);

        start_op(8'h80, 8'h80, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_done(n);
        chk("op3_latency", 32'(n), 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_sum", i), 32'(sum), 32'h00);
            chk($sformatf("bp%0d_cout", i), 32'(cout), 32'd1);
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_ready", i), 32'(in_ready), 32'd0);
        end
        release_out();
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_keep_sum", 32'(sum), 32'h00);
        chk("bp_keep_cout", 32'(cout), 32'd1);

        start_op(8'hAA, 8'h55, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_ni = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'h00);
        start_op(8'h10, 8'h20, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_done(n);
        chk("op4_latency", 32'(n), 32'd9);
        chk("op4_sum", 32'(sum), 32'h30);
        chk("op4_cout", 32'(cout), 32'd0);
        release_out();

`ifdef BSA_SUB_EN
        start_op(8'h05, 8'h07, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_done(n);
        chk("sub1_sum", 32'(sum), 32'hFE);
        chk("sub1_cout", 32'(cout), 32'd0);
        release_out();
        start_op(8'h07, 8'h05, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_done(n);
        chk("sub2_sum", 32'(sum), 32'h02);
        chk("sub2_cout", 32'(cout), 32'd1);
        release_out();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
